quad_gate_bist: RTL
===================

Name: quad_gate_bist

Overview:
- On-chip stimulus/response engine for the 4-bit quad-gate cells (quad_and and siblings).
- Drives every one of the 256 (a,b) input combinations into the gate under test and captures y after a settle interval.
- Compacts the responses into an 8-bit MISR signature and reports pass/fail against a golden signature.
- Sits beside the CPU's common cells as a self-test path, selected by the top-level test mux.

Parameters:
- SETTLE, default 1: cycles a vector is held before y is captured; legal range 1..15.
- SEED, default 8'h00: MISR initial value loaded on start.
- GOLDEN_SIG, default 8'h00: expected final signature; the integrator overrides it per gate type.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- a  output  4  stimulus to gate input a.
- b  output  4  stimulus to gate input b.
- y  input  4  response from gate under test.
- busy  output  1  high from APPLY through COMPARE.
- done  output  1  run complete; held until next start or reset.
- pass  output  1  signature == GOLDEN_SIG; valid only while done=1.
- signature  output  8  final MISR value; valid only while done=1.

Behaviour:
- Reset: one clock, asynchronous, active-low.
  - rst_n=0 asynchronously forces state=IDLE; vec, MISR, settle counter all 0.
  - a=b=0, busy=done=pass=0, signature=0.
  - Reset mid-run aborts with no partial result.
- Vector mapping: 8-bit counter vec; a=vec[3:0], b=vec[7:4]. a and b are registered and change only on APPLY entry.
- FSM:
  - IDLE: start=1 -> load MISR=SEED, vec=0 -> APPLY.
  - APPLY: hold a/b for SETTLE cycles (down-counter) -> CAPTURE.
  - CAPTURE (1 cycle): MISR <= {m[6:0],1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {4'b0,y}, polynomial x^8+x^4+x^3+x^2+1.
    - If vec==8'hFF -> COMPARE.
    - Otherwise vec<=vec+1 -> APPLY.
  - COMPARE (1 cycle): signature<=MISR; pass<=(MISR==GOLDEN_SIG) -> DONE.
  - DONE: done=1, busy=0. start=1 clears done/pass and restarts exactly as from IDLE, in the same cycle.
- Latency: done rises 256*(SETTLE+1)+2 rising edges after the edge that samples start.
- start while busy: ignored; no restart, no error.
- vec wrap: the terminal check uses vec==FF before increment; vec is never incremented past FF within a run.
- y is sampled only in CAPTURE; y changes in other states have no effect.

Optional Feature:
- Macro: QUAD_GATE_BIST_FIRST_FAIL_EN.
- When defined:
  - Adds an internal AND golden model (expected = a & b) compared in each CAPTURE.
  - Adds outputs fail_seen (1 bit) and fail_index (8 bits).
  - fail_index latches vec of the first mismatching vector; later mismatches are ignored.
  - Both clear on reset and on start.
- When undefined: these ports and this logic are absent; signature-only checking.

Decomposition:
- Shared package quad_gate_bist_pkg holds:
  - state enum (IDLE, APPLY, CAPTURE, COMPARE, DONE; 3-bit)
  - MISR_POLY = 8'h1D
  - VEC_LAST = 8'hFF
- Sub-module misr8 (clk, rst_n, load, seed, en, din[3:0], sig[7:0]) is natural. It is reusable for other cell BISTs.

Test Plan:
- Reset mid-run: pulse start, run 100 cycles, assert rst_n=0 -> a=b=0, busy=done=pass=0, signature=0 immediately, without waiting for a clock edge. After release the block stays IDLE.
- Good AND, SETTLE=1: bench connects y=a&b and sets GOLDEN_SIG to the reference-model signature.
  - busy rises one cycle after start.
  - done rises at edge 514.
  - pass=1 and signature equals the model value.
- Sequence check, SETTLE=3: monitor a/b. Values step 0x0/0x0, 0x1/0x0 … 0xF/0xF in order, each held 4 cycles; done at edge 1026.
- Stuck-at fault: force y=4'b0000 with the same GOLDEN_SIG -> pass=0 and signature equals the model's all-zero-response value (SEED-shifted, 8'h00 for SEED=0).
- Start while busy, then restart from DONE:
  - A start pulse mid-run causes no change to vec progression.
  - start in DONE clears done/pass next cycle; the second run gives an identical signature.
- With QUAD_GATE_BIST_FIRST_FAIL_EN: y[0] stuck at 0 -> fail_seen=1, fail_index=8'h11 (a=0001, b=0001). A fault-free run leaves fail_seen=0.

Source files
------------

// File: rtl/quad_gate_bist_pkg.sv
// Shared types and constants for the quad-gate BIST engine.
// Also consumed by the reusable misr8 compactor.
package quad_gate_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    CAPTURE,
    COMPARE,
    DONE
  } state_t;

  localparam logic [7:0] MISR_POLY = 8'h1D;
  localparam logic [7:0] VEC_LAST  = 8'hFF;

  // x^8+x^4+x^3+x^2+1 shift with the response folded into the low nibble
  function automatic logic [7:0] misr_step(
    input logic [7:0] m,
    input logic [3:0] d
  );
    logic [7:0] fb;
    fb = m[7] ? MISR_POLY : 8'h00;
    return {m[6:0], 1'b0} ^ fb ^ {4'b0000, d};
  endfunction

endpackage

// File: rtl/quad_gate_bist_misr8.sv
// 8-bit MISR with 4-bit parallel input, reusable by other cell BISTs.
// load takes priority over en.
module misr8
  import quad_gate_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  input  logic [3:0] din,
  output logic [7:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= 8'h00;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/quad_gate_bist.sv
// Exhaustive stimulus/signature BIST for 4-bit quad-gate cells.
// Define QUAD_GATE_BIST_FIRST_FAIL_EN for first-failing-vector capture.
module quad_gate_bist
  import quad_gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE     = 1,
  parameter logic [7:0]  SEED       = 8'h00,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] a,
  output logic [3:0] b,
  input  logic [3:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
`ifdef QUAD_GATE_BIST_FIRST_FAIL_EN
  output logic       fail_seen,
  output logic [7:0] fail_index,
`endif
  output logic [7:0] signature
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t     state;
  logic [7:0] vec;
  logic [7:0] vec_nxt;
  logic [3:0] cnt;
  logic [7:0] misr;
  logic       launch;
  logic       capture;

  assign launch  = start && ((state == IDLE) || (state == DONE));
  assign capture = (state == CAPTURE);
  assign vec_nxt = vec + 8'd1;

  misr8 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .seed  (SEED),
    .en    (capture),
    .din   (y),
    .sig   (misr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 8'h00;
      cnt       <= 4'h0;
      a         <= 4'h0;
      b         <= 4'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 8'h00;
    end else if (launch) begin
      state <= APPLY;
      vec   <= 8'h00;
      cnt   <= CNT_INIT;
      a     <= 4'h0;
      b     <= 4'h0;
      busy  <= 1'b1;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        APPLY: begin
          if (cnt == 4'h0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CAPTURE: begin
          if (vec == VEC_LAST) begin
            state <= COMPARE;
          end else begin
            vec   <= vec_nxt;
            a     <= vec_nxt[3:0];
            b     <= vec_nxt[7:4];
            cnt   <= CNT_INIT;
            state <= APPLY;
          end
        end
        COMPARE: begin
          signature <= misr;
          pass      <= (misr == GOLDEN_SIG);
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: done <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QUAD_GATE_BIST_FIRST_FAIL_EN
  // Golden AND model; only the first miscompare is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen  <= 1'b0;
      fail_index <= 8'h00;
    end else if (launch) begin
      fail_seen  <= 1'b0;
      fail_index <= 8'h00;
    end else if (capture && !fail_seen && (y != (a & b))) begin
      fail_seen  <= 1'b1;
      fail_index <= vec;
    end
  end
`endif

endmodule
